// File: rtl/fabscalar_exec_pkg.sv
// Shared execution-pipe definitions: flag bit positions, packet layout, stage limit.
package fabscalar_exec_pkg;

  localparam int unsigned FLAG_EXECUTED   = 2;
  localparam int unsigned FLAG_EXCEPTION  = 1;
  localparam int unsigned FLAG_MISPREDICT = 0;

  // Deepest pipe the multiply/divide model supports
  localparam int unsigned MAX_LATENCY = 8;

  localparam int unsigned DEF_SIZE_DATA          = 32;
  localparam int unsigned DEF_SIZE_PHYSICAL_LOG  = 7;
  localparam int unsigned DEF_SIZE_ACTIVELIST_LOG = 7;
  localparam int unsigned DEF_EXECUTION_FLAGS    = 6;

  typedef struct packed {
    logic [2*DEF_SIZE_DATA-1:0]         result;
    logic [DEF_EXECUTION_FLAGS-1:0]     flags;
    logic [DEF_SIZE_PHYSICAL_LOG-1:0]   phyDest;
    logic [DEF_SIZE_ACTIVELIST_LOG-1:0] alId;
  } exec_pkt_t;

endpackage

// File: rtl/complex_pipe_stage.sv
// One pipeline slot: valid bit plus payload, loaded on enable, valid cleared on flush.
module complex_pipe_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  // Valid bit: flush wins over load so an entering packet is also dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= valid_d;
    end
  end

  // Payload: content is irrelevant once the valid bit is cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/complex_exec_pipe.sv
// Fixed-latency delay line after the Complex ALU with writeback stall and flush.
module complex_exec_pipe
  import fabscalar_exec_pkg::*;
#(
  parameter int unsigned LATENCY             = 4,
  parameter int unsigned SIZE_DATA           = DEF_SIZE_DATA,
  parameter int unsigned SIZE_PHYSICAL_LOG   = DEF_SIZE_PHYSICAL_LOG,
  parameter int unsigned SIZE_ACTIVELIST_LOG = DEF_SIZE_ACTIVELIST_LOG,
  parameter int unsigned EXECUTION_FLAGS     = DEF_EXECUTION_FLAGS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid_i,
  input  logic [2*SIZE_DATA-1:0]         result_i,
  input  logic [EXECUTION_FLAGS-1:0]     flags_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]   phyDest_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] alId_i,
  output logic                           ready_o,
  input  logic                           recoverFlag_i,
  input  logic                           wbGrant_i,
  output logic                           valid_o,
  output logic [2*SIZE_DATA-1:0]         result_o,
  output logic [EXECUTION_FLAGS-1:0]     flags_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]   phyDest_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] alId_o,
  output logic [$clog2(LATENCY+1)-1:0]   inFlight_o
);

  localparam int unsigned STAGES = (LATENCY == 0) ? 1 :
                                   ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
  localparam int unsigned CNT_W  = $clog2(LATENCY+1);
  localparam int unsigned PKT_W  = 2*SIZE_DATA + EXECUTION_FLAGS +
                                   SIZE_PHYSICAL_LOG + SIZE_ACTIVELIST_LOG;

  logic             advance;
  logic             accepted;
  logic             consumed;
  logic [PKT_W-1:0] in_data;
  logic             stage_valid [STAGES];
  logic [PKT_W-1:0] stage_data  [STAGES];
  logic             link_valid  [STAGES];
  logic [PKT_W-1:0] link_data   [STAGES];

  // The whole line shifts unless a valid output is being refused
  assign advance  = !valid_o || wbGrant_i;
  assign ready_o  = advance;
  assign accepted = valid_i && advance;
  assign consumed = valid_o && wbGrant_i;
  assign in_data  = {result_i, flags_i, phyDest_i, alId_i};

  // Stage chain: stage 0 takes the input packet, every later stage its predecessor
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign link_valid[k] = valid_i;
      assign link_data[k]  = in_data;
    end else begin : g_body
      assign link_valid[k] = stage_valid[k-1];
      assign link_data[k]  = stage_data[k-1];
    end

    complex_pipe_stage #(
      .WIDTH(PKT_W)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load   (advance),
      .clear  (recoverFlag_i),
      .valid_d(link_valid[k]),
      .data_d (link_data[k]),
      .valid_q(stage_valid[k]),
      .data_q (stage_data[k])
    );
  end

  // Outputs come straight from the last stage's flops
  assign valid_o = stage_valid[STAGES-1];
  assign {result_o, flags_o, phyDest_o, alId_o} = stage_data[STAGES-1];

  // Occupancy: +1 per accept, -1 per consume, zeroed by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inFlight_o <= '0;
    end else if (recoverFlag_i) begin
      inFlight_o <= '0;
    end else if (accepted && !consumed) begin
      inFlight_o <= inFlight_o + CNT_W'(1);
    end else if (consumed && !accepted) begin
      inFlight_o <= inFlight_o - CNT_W'(1);
    end
  end

endmodule

// File: doc/complex_exec_pipe.md
# complex_exec_pipe

Fixed-latency pipeline stage directly downstream of the Complex ALU. It accepts one Complex ALU result per cycle with its destination tags and execution flags. It delays each result by LATENCY cycles to model the multi-cycle multiply/divide unit, then presents it on the shared writeback port. It supports writeback backpressure (grant-based stall) and a full flush on branch-mispredict recovery.

## Interface
- LATENCY, 4: number of pipeline stages; legal range 1..8.
- SIZE_DATA, 32: operand width; the result is 2*SIZE_DATA.
- SIZE_PHYSICAL_LOG, 7: physical register tag width.
- SIZE_ACTIVELIST_LOG, 7: active-list index width.
- EXECUTION_FLAGS, 6: flag vector width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- valid_i  in  1  input packet valid.
- result_i  in  2*SIZE_DATA  Complex ALU result.
- flags_i  in  EXECUTION_FLAGS  Complex ALU flags; bit2 = executed, bit1 = exception, bit0 = mispredict.
- phyDest_i  in  SIZE_PHYSICAL_LOG  destination physical tag.
- alId_i  in  SIZE_ACTIVELIST_LOG  active-list index.
- ready_o  out  1  stage can accept a packet this cycle.
- recoverFlag_i  in  1  flush all in-flight packets.
- wbGrant_i  in  1  writeback port accepts the output packet this cycle.
- valid_o  out  1  output packet valid.
- result_o, flags_o, phyDest_o, alId_o  out  (as the corresponding inputs)  output packet.
- inFlight_o  out  $clog2(LATENCY+1)  count of valid packets held, 0..LATENCY.

## Operation
- Storage is LATENCY stages, each holding {valid, result, flags, phyDest, alId}. Stage 0 is the input side; stage LATENCY-1 drives the outputs.
- advance = !valid_o || wbGrant_i. ready_o = advance. Both are combinational.
- On an advancing edge:
  - Every stage k>0 loads stage k-1.
  - Stage 0 loads the input packet, with valid = valid_i.
  - Bubbles propagate; there is no compaction.
- On a non-advancing edge, all stages hold.
- Handshake:
  - A packet is accepted when valid_i && ready_o.
  - An output is consumed when valid_o && wbGrant_i.
  - Output fields stay stable while valid_o=1 and wbGrant_i=0.
- Flush: recoverFlag_i=1 at an edge clears every valid bit, including any packet being accepted that cycle. It overrides advance. Data fields are don't-care.
- inFlight_o is a registered counter. Next value = current + accepted − consumed. Flush forces it to 0. It never exceeds LATENCY and never goes below 0.
- Payload passes through unmodified; there is no arithmetic on result or flags.
- Reset: all valids 0, all data 0, inFlight_o=0, valid_o=0. Outputs show zeros. Reset asserted mid-operation discards all packets immediately, because it is asynchronous.

## Timing
- With no stall, a packet presented in cycle n is valid on the outputs in cycle n+LATENCY.
- Each cycle with valid_o=1 and wbGrant_i=0 adds exactly one cycle to every held packet.
- Throughput is 1 packet/cycle while wbGrant_i=1.
- Full and stalled: ready_o=0, so an upstream valid_i is not accepted; the issue logic must hold it.
- Simultaneous accept and consume in the same edge leaves inFlight_o unchanged.
- recoverFlag_i together with wbGrant_i: the output packet in that cycle is still consumed (grant sampled the same cycle), and everything is cleared at the edge.
- LATENCY=1: a single stage, so the output is a registered copy of the input with the same handshake.

## Structure
- Shared package fabscalar_exec_pkg holds:
  - flag bit indices (FLAG_EXECUTED=2, FLAG_EXCEPTION=1, FLAG_MISPREDICT=0);
  - the packet struct {result, flags, phyDest, alId};
  - the stage-count limit constant.
- Sub-module complex_pipe_stage: one valid+payload register with load-enable and clear inputs, instantiated LATENCY times via generate. Top level contains the advance logic and the inFlight counter.

## Test plan
- LATENCY=4, wbGrant_i=1, one packet (result=64'h0000_0001_FFFF_FFFE, flags=6'b011100, phyDest=5, alId=9) at cycle 0 → valid_o=1 at cycle 4 only, fields identical; inFlight_o goes 1,1,1,1,0.
- Back-to-back packets over 10 cycles with grant=1 → 10 outputs in order on cycles 4..13; ready_o stays 1.
- Fill the pipe, then hold wbGrant_i=0 for 3 cycles → output is stable, ready_o=0, inFlight_o=4; the held input is accepted on the cycle grant returns; no loss or duplication.
- 3 packets in flight, recoverFlag_i=1 with valid_i=1 → next cycle inFlight_o=0; no valid_o in the following 4 cycles.
- Reset asserted between clock edges with packets in flight → valid_o and inFlight_o drop to 0 asynchronously; first packet after release emerges after LATENCY cycles.
- Flags 6'b000110 (SYSCALL) → passed through unchanged alongside result=0.
